// File: rtl/random_engine_seq_ctrl.sv
// random_engine_seq_ctrl: seed/warm-up/run control FSM with burst mode for the LFSR random engine
module random_engine_seq_ctrl #(
    parameter int CNT_W  = 8,
    parameter int WARMUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] burst_len,
    output logic             seed_load,
    output logic             lfsr_en,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             active,
    output logic             done,
    output logic [CNT_W-1:0] count
);
    localparam int WW = WARMUP > 0 ? $clog2(WARMUP + 1) : 1;
    localparam logic [1:0] IDLE = 2'd0, SEED = 2'd1, WARM = 2'd2, RUN = 2'd3;
    localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP);
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, len_q, len_d;
    logic             mode_q, mode_d, done_q, done_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic             xfer, last;
    assign xfer      = state_q == RUN && out_rdy;
    assign last      = xfer && mode_q && count_q + CNT_W'(1) == len_q;
    assign seed_load = state_q == SEED;
    assign lfsr_en   = state_q == WARM || xfer;
    assign out_val   = state_q == RUN;
    assign active    = state_q != IDLE;
    assign done      = done_q;
    assign count     = count_q;
    always_comb begin
        state_d = state_q;
        count_d = xfer ? count_q + CNT_W'(1) : count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        warm_d  = warm_q;
        done_d  = last;
        case (state_q)
            IDLE: if (start && (!mode || burst_len != '0)) begin
                state_d = SEED;
                count_d = '0;
                len_d   = burst_len;
                mode_d  = mode;
            end
            SEED: begin
                warm_d  = WARM_INIT;
                state_d = WARMUP > 0 ? WARM : RUN;
            end
            WARM: begin
                warm_d  = warm_q - WW'(1);
                state_d = warm_q == WW'(1) ? RUN : WARM;
            end
            default: state_d = last ? IDLE : RUN;
        endcase
        // stop aborts any run; a coincident transfer has already been counted above
        if (state_q != IDLE && stop) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            warm_q  <= warm_d;
        end
    end
endmodule

// File: tb/tb_random_engine_seq_ctrl.sv
// tb_random_engine_seq_ctrl: directed checks of three parameterisations sharing one stimulus bus
module tb_random_engine_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, out_rdy = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic sl_a, le_a, ov_a, ac_a, dn_a;
    logic sl_b, le_b, ov_b, ac_b, dn_b;
    logic sl_c, le_c, ov_c, ac_c, dn_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    random_engine_seq_ctrl #(.CNT_W(8), .WARMUP(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .burst_len(burst_len),
        .seed_load(sl_a), .lfsr_en(le_a), .out_val(ov_a), .out_rdy(out_rdy),
        .active(ac_a), .done(dn_a), .count(cnt_a));
    random_engine_seq_ctrl #(.CNT_W(2), .WARMUP(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .burst_len(burst_len[1:0]),
        .seed_load(sl_b), .lfsr_en(le_b), .out_val(ov_b), .out_rdy(out_rdy),
        .active(ac_b), .done(dn_b), .count(cnt_b));
    random_engine_seq_ctrl #(.CNT_W(8), .WARMUP(0)) dut_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .burst_len(burst_len),
        .seed_load(sl_c), .lfsr_en(le_c), .out_val(ov_c), .out_rdy(out_rdy),
        .active(ac_c), .done(dn_c), .count(cnt_c));

    wire [4:0] vec_a = {sl_a, le_a, ov_a, ac_a, dn_a};
    wire [4:0] vec_b = {sl_b, le_b, ov_b, ac_b, dn_b};
    wire [4:0] vec_c = {sl_c, le_c, ov_c, ac_c, dn_c};

    // Drive one cycle's inputs just after the falling edge and settle before checking.
    task automatic step(input logic r, input logic s, input logic p, input logic m,
                        input logic [7:0] l, input logic rd);
        @(negedge clk);
        rst = r; start = s; stop = p; mode = m; burst_len = l; out_rdy = rd;
        #1;
    endtask

    task automatic test_reset;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0);
            n_chk++;
            if (vec_a !== 5'b0 || vec_b !== 5'b0 || vec_c !== 5'b0 ||
                cnt_a !== 8'd0 || cnt_b !== 2'd0 || cnt_c !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: outs a=%b b=%b c=%b cnt a=%0d b=%0d c=%0d, want all 0",
                         i, vec_a, vec_b, vec_c, cnt_a, cnt_b, cnt_c);
            end
        end
    endtask

    // {seed_load, lfsr_en, out_val, active, done}
    task automatic test_burst(input logic bp);
        logic [4:0] exp [12];
        logic [7:0] cexp [12];
        logic rd;
        int last;
        step(0, 0, 0, 0, 0, 0);
        if (!bp) begin
            exp  = '{5'b00000, 5'b10010, 5'b01010, 5'b01010, 5'b01010, 5'b01010,
                     5'b01110, 5'b01110, 5'b01110, 5'b00001, 5'b00000, 5'b00000};
            cexp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
            last = 9;
        end else begin
            exp  = '{5'b00000, 5'b10010, 5'b01010, 5'b01010, 5'b01010, 5'b01010,
                     5'b01110, 5'b00110, 5'b00110, 5'b01110, 5'b01110, 5'b00001};
            cexp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
            last = 11;
        end
        for (int t = 0; t <= last; t++) begin
            rd = !(bp && (t == 7 || t == 8));
            step(1, t == 0, 0, 1, 8'd3, rd);
            n_chk++;
            if (vec_a !== exp[t] || (t > 0 && cnt_a !== cexp[t])) begin
                n_fail++;
                $display("FAIL burst bp=%0d t=%0d: outs=%b count=%0d, want outs=%b count=%0d",
                         bp, t, vec_a, cnt_a, exp[t], cexp[t]);
            end
        end
    endtask

    task automatic test_continuous;
        logic [1:0] cexp [5];
        cexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        for (int t = 1; t <= 6; t++) step(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, k == 4, 1, 0, k != 4);
            n_chk++;
            if (cnt_b !== cexp[k] || ov_b !== 1'b1) begin
                n_fail++;
                $display("FAIL cont_count k=%0d: count=%0d out_val=%b, want count=%0d out_val=1",
                         k, cnt_b, ov_b, cexp[k]);
            end
        end
        step(1, 0, 0, 0, 0, 1);
        n_chk++;
        if (vec_b !== 5'b0 || cnt_b !== 2'd1) begin
            n_fail++;
            $display("FAIL cont_stop: outs=%b count=%0d, want outs=00000 count=1", vec_b, cnt_b);
        end
        step(1, 0, 0, 0, 0, 1);
        n_chk++;
        if (dn_b !== 1'b0 || ac_b !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_nodone: done=%b active=%b, want 0 0", dn_b, ac_b);
        end
    endtask

    task automatic test_stop_final;
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 8'd3, 1);
        for (int t = 1; t <= 7; t++) step(1, 0, 0, 1, 8'd3, 1);
        step(1, 0, 1, 1, 8'd3, 1);
        n_chk++;
        if (le_a !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_final_lfsr: lfsr_en=%b, want 1", le_a);
        end
        step(1, 0, 0, 1, 8'd3, 1);
        n_chk++;
        if (vec_a !== 5'b00001 || cnt_a !== 8'd3) begin
            n_fail++;
            $display("FAIL stop_final: outs=%b count=%0d, want outs=00001 count=3", vec_a, cnt_a);
        end
    endtask

    task automatic test_zero_len;
        step(1, 1, 0, 1, 8'd0, 1);
        for (int t = 0; t < 3; t++) begin
            step(1, 0, 0, 1, 8'd0, 1);
            n_chk++;
            if (vec_a !== 5'b0 || cnt_a !== 8'd3) begin
                n_fail++;
                $display("FAIL zero_len t=%0d: outs=%b count=%0d, want outs=00000 count=3", t, vec_a, cnt_a);
            end
        end
    endtask

    task automatic test_reset_mid_warm;
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 8'd5, 1);
        step(1, 0, 0, 1, 8'd5, 1);
        step(1, 0, 0, 1, 8'd5, 1);
        n_chk++;
        if (vec_a !== 5'b01010) begin
            n_fail++;
            $display("FAIL in_warm: outs=%b, want 01010", vec_a);
        end
        step(0, 0, 0, 1, 8'd5, 1);
        step(1, 0, 0, 1, 8'd5, 1);
        n_chk++;
        if (vec_a !== 5'b0 || cnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_warm: outs=%b count=%0d, want outs=00000 count=0", vec_a, cnt_a);
        end
    endtask

    task automatic test_warmup0;
        logic [4:0] exp [5];
        exp = '{5'b00000, 5'b10010, 5'b01110, 5'b01110, 5'b00001};
        step(0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 5; t++) begin
            step(1, t == 0, t == 0, 1, 8'd2, 1);
            n_chk++;
            if (vec_c !== exp[t]) begin
                n_fail++;
                $display("FAIL warmup0 t=%0d: outs=%b, want %b", t, vec_c, exp[t]);
            end
        end
        n_chk++;
        if (cnt_c !== 8'd2) begin
            n_fail++;
            $display("FAIL warmup0_count: count=%0d, want 2", cnt_c);
        end
    endtask

    task automatic test_back_to_back;
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 8'd1, 1);
        step(1, 0, 0, 1, 8'd1, 1);
        step(1, 0, 0, 1, 8'd1, 1);
        step(1, 1, 0, 1, 8'd1, 1);
        n_chk++;
        if (dn_c !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b, want 1", dn_c);
        end
        step(1, 0, 0, 1, 8'd1, 1);
        n_chk++;
        if (sl_c !== 1'b1 || cnt_c !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: seed_load=%b count=%0d, want 1 0", sl_c, cnt_c);
        end
    endtask

    initial begin
        test_reset;
        test_burst(0);
        test_burst(1);
        test_continuous;
        test_stop_final;
        test_zero_len;
        test_reset_mid_warm;
        test_warmup0;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/random_engine_seq_ctrl.md
# random_engine_seq_ctrl

Parametrised control FSM for the LFSR random engine. It generalises start/stop control with a seed-load phase, a configurable warm-up period, a valid/ready output handshake and a burst mode that emits exactly N values and then stops. It drives the datapath's seed-load and step enables and sits between the host I/O interface and the LFSR datapath.

## Interface
- CNT_W, default 8: width of the burst length and emitted-value counter.
- WARMUP, default 4: LFSR steps taken after seed load before the first output; 0 is legal.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
- start  input  1  begin a run; sampled only in IDLE.
- stop  input  1  abort the run; sampled in every non-IDLE state.
- mode  input  1  0 = continuous, 1 = burst; latched on accepted start.
- burst_len  input  CNT_W  number of values per burst; latched on accepted start.
- seed_load  output  1  datapath loads the seed this cycle.
- lfsr_en  output  1  datapath advances the LFSR this cycle.
- out_val  output  1  the datapath output holds a valid random value.
- out_rdy  input  1  the consumer accepts the value.
- active  output  1  the engine is in any non-IDLE state.
- done  output  1  one-cycle pulse after the final burst transfer.
- count  output  CNT_W  number of transfers completed in the current or last run.

## Operation
- States: IDLE, SEED, WARM, RUN. Outputs are Moore, except lfsr_en in RUN.
- IDLE:
  - All control outputs are 0.
  - start=1 and (mode=0 or burst_len!=0) -> SEED. On this edge mode and burst_len are latched and count is cleared to 0.
  - start with mode=1 and burst_len=0 is ignored; the FSM stays in IDLE and count is unchanged.
- SEED: seed_load=1 and active=1 for exactly one cycle. Next state is WARM if WARMUP>0, else RUN.
- WARM:
  - lfsr_en=1 and active=1.
  - The internal warm-up counter (width clog2(WARMUP+1)) is loaded in SEED and decrements each cycle. The FSM moves to RUN after exactly WARMUP WARM cycles.
- RUN:
  - out_val=1, active=1, lfsr_en = out_rdy.
  - A transfer is out_val & out_rdy. Each transfer increments count.
  - In continuous mode count wraps modulo 2^CNT_W.
  - In burst mode, a transfer that makes count equal the latched burst_len -> IDLE, and done=1 in the following cycle.
- stop=1 in SEED, WARM or RUN -> IDLE on the next edge, with no done pulse.
  - A transfer in the same cycle as stop is valid: lfsr_en=1 and count increments.
  - If that transfer is also the final burst transfer, done still pulses.
- start outside IDLE is ignored. start and stop together in IDLE: start wins, because stop is not sampled in IDLE.
- Changes to mode or burst_len mid-run have no effect.
- count holds its value in IDLE until the next accepted start.

## Timing
- Reset (rst=0 at an edge) gives: state=IDLE, count=0, done=0, seed_load=0, lfsr_en=0, out_val=0, active=0. This applies from any state, including mid-burst, and nothing is flushed to the consumer.
- Accepted start in cycle t:
  - SEED in cycle t+1.
  - WARM in cycles t+2 .. t+1+WARMUP.
  - First out_val=1 in cycle t+2+WARMUP.
- With out_rdy held high in burst mode:
  - Transfers occur in cycles t+2+WARMUP .. t+1+WARMUP+burst_len.
  - done=1 in cycle t+2+WARMUP+burst_len; state is IDLE in that cycle.
- done is registered and lasts exactly one cycle. A new start is accepted in the same cycle done is high.
- Backpressure: while out_rdy=0, out_val stays 1, lfsr_en=0 and the value is held.
- stop at cycle s: active=0 and out_val=0 from cycle s+1.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then start=0 for 5 cycles -> every output is 0 and count=0 throughout.
- Burst, no backpressure (WARMUP=4, mode=1, burst_len=3, out_rdy=1, start at t=0):
  - seed_load at t=1.
  - lfsr_en at t=2..5.
  - out_val at t=6..8.
  - done at t=9; count=3.
- Backpressure: as above with out_rdy=0 at t=7..8 -> out_val=1 and lfsr_en=0 at t=7..8; transfers at t=6, 9, 10; done at t=11.
- Continuous mode with CNT_W=2, 5 transfers, then stop -> count sequence 1,2,3,0,1; active=0 one cycle after stop; no done pulse.
- Corner cases:
  - Stop in the same cycle as the final burst transfer -> count=burst_len and done pulses.
  - Start with mode=1 and burst_len=0 -> FSM stays in IDLE.
  - rst=0 mid-WARM -> all outputs are 0 next cycle.
- WARMUP=0: start at t=0 -> seed_load at t=1, out_val at t=2.
